// File: rtl/mem_pkg.sv
// Shared types and address-map constants for the memory responder and its RAM.
package mem_pkg;

  typedef enum logic [1:0] {
    CMD_NONE    = 2'b00,
    CMD_READ    = 2'b01,
    CMD_WRITE   = 2'b10,
    CMD_ILLEGAL = 2'b11
  } mem_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  localparam logic [8:0] LED_ADDR  = 9'h100;
  localparam logic [8:0] SW_ADDR   = 9'h140;
  localparam int         RAM_DEPTH = 256;
  localparam int         RAM_AW    = 8;

endpackage

// File: rtl/ram_sp.sv
// Single-port RAM: synchronous write, combinational read.
module ram_sp #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 256,
  parameter int AW        = 8,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Load/store responder: latches a request, waits WAIT_CYCLES, then accesses RAM or
// the LED/switch registers and acknowledges with a one-cycle mem_ready.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2,
  parameter     INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_err,
  input  logic [7:0]        sw,
  output logic [7:0]        led
);

  state_t            state, state_next;
  mem_cmd_t          req_cmd;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]        wait_cnt;
  logic              err_q;
  logic              capture, access;
  logic              is_ram, is_led, is_sw, acc_err, wr_ok, ram_we, led_we;
  logic [DATA_W-1:0] ram_q, rd_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    access     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_cmd != CMD_NONE) begin
          capture    = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd0) begin
          access     = 1'b1;
          state_next = ST_ACK;
        end
      end
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Decode works only on the latched request, so input changes after capture are invisible.
  always_comb begin
    is_ram   = req_addr < ADDR_W'(RAM_DEPTH);
    is_led   = req_addr == ADDR_W'(LED_ADDR);
    is_sw    = req_addr == ADDR_W'(SW_ADDR);
    acc_err  = (req_cmd == CMD_ILLEGAL) || !(is_ram || is_led || is_sw) ||
               (is_sw && req_cmd == CMD_WRITE);
    wr_ok    = access && (req_cmd == CMD_WRITE) && !acc_err;
    ram_we   = wr_ok && is_ram;
    led_we   = wr_ok && is_led;
    rd_value = '0;
    if (req_cmd == CMD_READ && !acc_err) begin
      if (is_ram) begin
        rd_value = ram_q;
      end else if (is_led) begin
        rd_value = {{(DATA_W-8){1'b0}}, led};
      end else begin
        rd_value = {{(DATA_W-8){1'b0}}, sw};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_cmd   <= CMD_NONE;
      req_addr  <= '0;
      req_wdata <= '0;
      wait_cnt  <= 4'd0;
      err_q     <= 1'b0;
      mem_rdata <= '0;
      led       <= 8'h00;
    end else begin
      if (capture) begin
        req_cmd   <= mem_cmd_t'(mem_cmd);
        req_addr  <= mem_addr;
        req_wdata <= mem_wdata;
        wait_cnt  <= 4'(WAIT_CYCLES - 1);
      end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (access) begin
        mem_rdata <= rd_value;
        err_q     <= acc_err;
      end
      if (led_we) begin
        led <= req_wdata[7:0];
      end
    end
  end

  assign mem_ready = (state == ST_ACK);
  assign mem_err   = (state == ST_ACK) && err_q;

  ram_sp #(
    .DATA_W    (DATA_W),
    .DEPTH     (RAM_DEPTH),
    .AW        (RAM_AW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (req_addr[RAM_AW-1:0]),
    .wdata (req_wdata),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Randomised self-checking bench for mem_responder against a transaction-level model
// of the address map, plus directed cases with hand-computed results.
module tb_mem_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        mem_err;
  logic [7:0]  sw;
  logic [7:0]  led;

  typedef struct {
    int          ack_cyc;
    logic        err;
    logic [15:0] rdata;
    logic [7:0]  led;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [15:0] ram_m [256];
  logic [7:0]  led_m = 8'h00;
  exp_t        exp_q[$];
  logic [15:0] cur_rdata = 16'h0000;
  logic [7:0]  cur_led = 8'h00;

  mem_responder #(
    .DATA_W      (16),
    .ADDR_W      (9),
    .WAIT_CYCLES (W),
    .INIT_FILE   ("")
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .mem_err   (mem_err),
    .sw        (sw),
    .led       (led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp_v, cyc);
    end
  endtask

  // Architectural effect of one request on the model: result word, error, side effects.
  task automatic model_access(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd,
                              output logic err, output logic [15:0] rd);
    err = 1'b0;
    rd  = 16'h0000;
    if (cmd == 2'b11) begin
      err = 1'b1;
    end else if (cmd == 2'b01) begin
      if (addr < 9'h100)       rd = ram_m[addr[7:0]];
      else if (addr == 9'h100) rd = {8'h00, led_m};
      else if (addr == 9'h140) rd = {8'h00, sw};
      else                     err = 1'b1;
    end else if (cmd == 2'b10) begin
      if (addr < 9'h100)       ram_m[addr[7:0]] = wd;
      else if (addr == 9'h100) led_m = wd[7:0];
      else                     err = 1'b1;
    end
  endtask

  task automatic scramble_inputs();
    mem_cmd   = 2'($urandom_range(0, 3));
    mem_addr  = 9'($urandom);
    mem_wdata = 16'($urandom);
  endtask

  // Presents one request in an IDLE cycle (entered at posedge+1) and returns at the
  // posedge+1 right after the acknowledge, ready for a back-to-back request.
  task automatic applyStimulus(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd,
                               input bit scramble, output int lat, output logic a_err,
                               output logic [15:0] a_rdata);
    exp_t        e;
    logic        m_err;
    logic [15:0] m_rd;
    mem_cmd   = cmd;
    mem_addr  = addr;
    mem_wdata = wd;
    model_access(cmd, addr, wd, m_err, m_rd);
    e.ack_cyc = cyc + 1 + W;
    e.err     = m_err;
    e.rdata   = m_rd;
    e.led     = led_m;
    exp_q.push_back(e);
    @(posedge clk); #1;
    lat = 0;
    a_err = 1'b0;
    a_rdata = 16'h0000;
    if (scramble) scramble_inputs();
    for (int n = 1; n <= W + 6; n++) begin
      @(negedge clk);
      if (mem_ready === 1'b1) begin
        lat = n;
        a_err = mem_err;
        a_rdata = mem_rdata;
        break;
      end
      if (scramble) scramble_inputs();
    end
    checkOutput("ack_seen", 32'(lat != 0), 32'd1);
    if (lat == 0) exp_q.delete();
    @(posedge clk); #1;
  endtask

  // Cycle-by-cycle comparison of every output against the model's expectations.
  always @(negedge clk) begin
    if (!rst_n) begin
      cur_led   = 8'h00;
      cur_rdata = 16'h0000;
      checkOutput("rst_ready", 32'(mem_ready), 32'd0);
      checkOutput("rst_err", 32'(mem_err), 32'd0);
    end else begin
      while (exp_q.size() > 0 && exp_q[0].ack_cyc < cyc) begin
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].ack_cyc == cyc) begin
        checkOutput("ready_at_ack", 32'(mem_ready), 32'd1);
        checkOutput("err_at_ack", 32'(mem_err), 32'(exp_q[0].err));
        cur_rdata = exp_q[0].rdata;
        cur_led   = exp_q[0].led;
        void'(exp_q.pop_front());
      end else begin
        checkOutput("ready_idle", 32'(mem_ready), 32'd0);
        checkOutput("err_idle", 32'(mem_err), 32'd0);
      end
      checkOutput("rdata", 32'(mem_rdata), 32'(cur_rdata));
      checkOutput("led", 32'(led), 32'(cur_led));
    end
  end

  initial begin
    int          lat;
    logic        a_err;
    logic [15:0] a_rd;
    logic [1:0]  cmd;
    logic [8:0]  addr;
    int          r;

    rst_n = 1'b0;
    mem_cmd = 2'b00;
    mem_addr = 9'h000;
    mem_wdata = 16'h0000;
    sw = 8'h00;
    #1;
    checkOutput("reset_ready", 32'(mem_ready), 32'd0);
    checkOutput("reset_rdata", 32'(mem_rdata), 32'd0);
    checkOutput("reset_led", 32'(led), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int a = 0; a < 256; a++) begin
      applyStimulus(2'b10, 9'(a), 16'($urandom), 1'b0, lat, a_err, a_rd);
    end

    applyStimulus(2'b10, 9'h005, 16'hABCD, 1'b0, lat, a_err, a_rd);
    applyStimulus(2'b01, 9'h005, 16'h0000, 1'b0, lat, a_err, a_rd);
    checkOutput("read5_latency", 32'(lat), 32'd3);
    checkOutput("read5_data", 32'(a_rd), 32'hABCD);
    checkOutput("read5_err", 32'(a_err), 32'd0);

    applyStimulus(2'b10, 9'h010, 16'h1234, 1'b0, lat, a_err, a_rd);
    checkOutput("write_rdata_zero", 32'(a_rd), 32'd0);
    applyStimulus(2'b01, 9'h010, 16'h0000, 1'b0, lat, a_err, a_rd);
    checkOutput("raw_data", 32'(a_rd), 32'h1234);

    applyStimulus(2'b10, 9'h100, 16'h00A5, 1'b0, lat, a_err, a_rd);
    checkOutput("led_write", 32'(led), 32'hA5);
    sw = 8'h3C;
    applyStimulus(2'b01, 9'h140, 16'h0000, 1'b0, lat, a_err, a_rd);
    checkOutput("sw_read", 32'(a_rd), 32'h003C);

    applyStimulus(2'b10, 9'h140, 16'hFFFF, 1'b0, lat, a_err, a_rd);
    checkOutput("sw_write_err", 32'(a_err), 32'd1);
    checkOutput("sw_write_rdata", 32'(a_rd), 32'd0);
    applyStimulus(2'b01, 9'h180, 16'h0000, 1'b0, lat, a_err, a_rd);
    checkOutput("unmapped_err", 32'(a_err), 32'd1);
    checkOutput("unmapped_rdata", 32'(a_rd), 32'd0);
    applyStimulus(2'b11, 9'h100, 16'h00FF, 1'b0, lat, a_err, a_rd);
    checkOutput("illegal_err", 32'(a_err), 32'd1);
    checkOutput("illegal_rdata", 32'(a_rd), 32'd0);
    checkOutput("led_kept", 32'(led), 32'hA5);

    applyStimulus(2'b10, 9'h020, 16'h5A5A, 1'b0, lat, a_err, a_rd);
    mem_cmd = 2'b10;
    mem_addr = 9'h020;
    mem_wdata = 16'hFFFF;
    @(posedge clk); #2;
    rst_n = 1'b0;
    mem_cmd = 2'b00;
    #1;
    checkOutput("midrst_ready", 32'(mem_ready), 32'd0);
    checkOutput("midrst_err", 32'(mem_err), 32'd0);
    checkOutput("midrst_led", 32'(led), 32'd0);
    exp_q.delete();
    led_m = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(2'b01, 9'h020, 16'h0000, 1'b0, lat, a_err, a_rd);
    checkOutput("abandoned_write", 32'(a_rd), 32'h5A5A);

    applyStimulus(2'b01, 9'h010, 16'h0000, 1'b1, lat, a_err, a_rd);
    checkOutput("scrambled_read", 32'(a_rd), 32'h1234);

    for (int i = 0; i < 150; i++) begin
      sw = 8'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        mem_cmd = 2'b00;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      r = $urandom_range(0, 9);
      cmd = (r == 0) ? 2'b11 : (r <= 5) ? 2'b01 : 2'b10;
      r = $urandom_range(0, 9);
      if (r <= 5)      addr = 9'($urandom_range(0, 255));
      else if (r == 6) addr = 9'h100;
      else if (r == 7) addr = 9'h140;
      else             addr = 9'($urandom);
      applyStimulus(cmd, addr, 16'($urandom), 1'($urandom_range(0, 1)), lat, a_err, a_rd);
    end

    mem_cmd = 2'b00;
    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
